present_key_schedule80: RTL and testbench

//  PRESENT-80 key-schedule sequencer. It loads an 80-bit user key and applies the

---
 rtl/present_key_schedule80.sv | 152 +++++++++++++++
 tb/tb_present_key_schedule80.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/present_key_schedule80.sv
// present_key_schedule80: PRESENT-80 key-schedule sequencer. It loads an 80-bit user key
//   and streams round keys K1..K(ROUNDS+1) out over rk_valid/rk_ready, one key update per transfer.
// Latency: start accepted at cycle n -> K1 valid at n+1. With rk_ready held high, done pulses at n+ROUNDS+2.
// Backpressure: rk_valid & !rk_ready holds rk, rk_idx and key_state. start while busy is dropped.
// Ports: clk, rst (sync, active-high), key_in/start (load), busy, rk/rk_idx/rk_valid/rk_ready
//   (round-key stream), key_next/key_en (D/enable of the downstream 80-bit key register), done.
// Optional: define KEY_SCHED_INV_EN to add input dir (1 = inverse schedule from the final state).
module present_key_schedule80 #(
    parameter int ROUNDS = 31
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [79:0] key_in,
    input  logic        start,
`ifdef KEY_SCHED_INV_EN
    input  logic        dir,
`endif
    output logic        busy,
    output logic [63:0] rk,
    output logic [4:0]  rk_idx,
    output logic        rk_valid,
    input  logic        rk_ready,
    output logic [79:0] key_next,
    output logic        key_en,
    output logic        done
);

    localparam logic [4:0] LAST_IDX = 5'(ROUNDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic [79:0] key_state;
    logic [79:0] upd;
    logic        load;
    logic        xfer;
    logic        last;
    logic        inv_run;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
            4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
            4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
            4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
        endcase
        return y;
    endfunction

    // Forward update: rotate left 61, S-box top nibble, XOR round counter into bits 19:15.
    function automatic logic [79:0] fwd_step(input logic [79:0] k, input logic [4:0] i);
        logic [79:0] t;
        t          = {k[18:0], k[79:19]};
        t[79:76]   = sbox(t[79:76]);
        t[19:15]   = t[19:15] ^ i;
        return t;
    endfunction

`ifdef KEY_SCHED_INV_EN
    function automatic logic [3:0] sbox_inv(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'h5;  4'h1: y = 4'hE;  4'h2: y = 4'hF;  4'h3: y = 4'h8;
            4'h4: y = 4'hC;  4'h5: y = 4'h1;  4'h6: y = 4'h2;  4'h7: y = 4'hD;
            4'h8: y = 4'hB;  4'h9: y = 4'h4;  4'hA: y = 4'h6;  4'hB: y = 4'h3;
            4'hC: y = 4'h0;  4'hD: y = 4'h7;  4'hE: y = 4'h9;  default: y = 4'hA;
        endcase
        return y;
    endfunction

    // Undo fwd_step for round j: strip the counter, invert the S-box, rotate right 61.
    function automatic logic [79:0] inv_step(input logic [79:0] k, input logic [4:0] j);
        logic [79:0] t;
        t          = k;
        t[19:15]   = t[19:15] ^ j;
        t[79:76]   = sbox_inv(t[79:76]);
        return {t[60:0], t[79:61]};
    endfunction

    logic dir_q;
    assign inv_run = dir_q;
    // Inverse steps use the current index j; forward steps use the next index i = rk_idx+1.
    assign upd     = dir_q ? inv_step(key_state, rk_idx) : fwd_step(key_state, rk_idx + 5'd1);
`else
    assign inv_run = 1'b0;
    assign upd     = fwd_step(key_state, rk_idx + 5'd1);
`endif

    assign load     = (state == IDLE) && start;
    assign xfer     = rk_valid && rk_ready;
    assign last     = inv_run ? (rk_idx == 5'd0) : (rk_idx == LAST_IDX);
    assign busy     = (state != IDLE);
    assign rk       = key_state[79:16];
    assign key_next = load ? key_in : upd;
    // Gated by rst so the downstream register never loads during reset.
    assign key_en   = !rst && (load || (xfer && !last));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            key_state <= '0;
            rk_idx    <= '0;
            rk_valid  <= 1'b0;
            done      <= 1'b0;
`ifdef KEY_SCHED_INV_EN
            dir_q     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        key_state <= key_in;
                        rk_valid  <= 1'b1;
                        state     <= RUN;
`ifdef KEY_SCHED_INV_EN
                        dir_q     <= dir;
                        rk_idx    <= dir ? LAST_IDX : 5'd0;
`else
                        rk_idx    <= 5'd0;
`endif
                    end
                end
                RUN: begin
                    if (xfer) begin
                        if (last) begin
                            rk_valid <= 1'b0;
                            done     <= 1'b1;
                            state    <= DONE;
                        end else begin
                            key_state <= upd;
                            rk_idx    <= inv_run ? (rk_idx - 5'd1) : (rk_idx + 5'd1);
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_present_key_schedule80.sv
// tb_present_key_schedule80: self-checking bench for present_key_schedule80 (ROUNDS=31 and ROUNDS=1).
// Expected keys come from an arithmetic PRESENT-80 schedule model; inverse runs expect the
// forward key list reversed.
module tb_present_key_schedule80;

    logic        clk = 1'b0;
    logic        rst;
    logic [79:0] key_in;
    logic        start;
    logic        busy;
    logic [63:0] rk;
    logic [4:0]  rk_idx;
    logic        rk_valid;
    logic        rk_ready;
    logic [79:0] key_next;
    logic        key_en;
    logic        done;

    logic [79:0] b_key_in;
    logic        b_start;
    logic        b_busy;
    logic [63:0] b_rk;
    logic [4:0]  b_idx;
    logic        b_valid;
    logic        b_ready;
    logic [79:0] b_key_next;
    logic        b_key_en;
    logic        b_done;
`ifdef KEY_SCHED_INV_EN
    logic        dir;
    logic        b_dir;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    localparam int SB [16] = '{12, 5, 6, 11, 9, 0, 10, 13, 3, 14, 15, 8, 4, 7, 1, 2};

    logic [79:0] st [32];
    logic [68:0] exp_q [$];
    logic [63:0] got_q [$];

    always #5 clk = ~clk;

    present_key_schedule80 #(.ROUNDS(31)) dut (
        .clk(clk), .rst(rst), .key_in(key_in), .start(start),
`ifdef KEY_SCHED_INV_EN
        .dir(dir),
`endif
        .busy(busy), .rk(rk), .rk_idx(rk_idx), .rk_valid(rk_valid), .rk_ready(rk_ready),
        .key_next(key_next), .key_en(key_en), .done(done)
    );

    present_key_schedule80 #(.ROUNDS(1)) dut_b (
        .clk(clk), .rst(rst), .key_in(b_key_in), .start(b_start),
`ifdef KEY_SCHED_INV_EN
        .dir(b_dir),
`endif
        .busy(b_busy), .rk(b_rk), .rk_idx(b_idx), .rk_valid(b_valid), .rk_ready(b_ready),
        .key_next(b_key_next), .key_en(b_key_en), .done(b_done)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [79:0] rnd80();
        return {$urandom, $urandom, 16'($urandom)};
    endfunction

    // Reference update: 80-bit rotate by 61, S-box lookup on the top nibble, add counter at bit 15.
    function automatic logic [79:0] upd(input logic [79:0] k, input int r);
        logic [79:0] t;
        t        = (k << 61) | (k >> 19);
        t[79:76] = 4'(SB[t[79:76]]);
        t        = t ^ (80'(r) << 15);
        return t;
    endfunction

    task automatic fill_fwd(input logic [79:0] k);
        st[0] = k;
        for (int i = 1; i < 32; i++) st[i] = upd(st[i-1], i);
        exp_q.delete();
        for (int i = 0; i < 32; i++) exp_q.push_back({5'(i), st[i][79:16]});
    endtask

    // One complete run on the ROUNDS=31 instance; compares every transfer against exp_q.
    task automatic run(input logic [79:0] k, input bit dv, input int stall_pct,
                       input bit spam, input int exp_cyc);
        int          cyc;
        int          n_en;
        int          n_got;
        bit          fin;
        bit          stalled;
        logic [63:0] prk;
        logic [4:0]  pidx;
        logic [4:0]  fin_idx;
        fin_idx = dv ? 5'd0 : 5'd31;
        got_q.delete();
        prk = '0;
        pidx = '0;
        @(negedge clk);
        key_in   = k;
        start    = 1'b1;
        rk_ready = 1'b1;
`ifdef KEY_SCHED_INV_EN
        dir = dv;
`endif
        #1;
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        chk("load_en", key_en, 1);
        chk("load_next", key_next, k);
        n_en = 1; cyc = 0; n_got = 0; fin = 0; stalled = 0;
        while (!fin && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (spam) begin
                start  = ($urandom_range(1) == 1) || (rk_idx == fin_idx);
                key_in = rnd80();
            end else begin
                start = 1'b0;
            end
            rk_ready = ($urandom_range(99) >= stall_pct);
            #1;
            chk("busy_run", busy, 1);
            if (stalled) begin
                chk("stall_rk", rk, prk);
                chk("stall_idx", rk_idx, pidx);
            end
            stalled = 0;
            if (key_en) n_en++;
            if (done) begin
                fin = 1;
            end else if (rk_valid) begin
                if (rk_ready) begin
                    if (n_got < exp_q.size()) chk("key", {rk_idx, rk}, exp_q[n_got]);
                    else chk("extra_key", n_got, exp_q.size());
                    got_q.push_back(rk);
                    n_got++;
                end else begin
                    stalled = 1;
                    prk     = rk;
                    pidx    = rk_idx;
                end
            end
        end
        start = 1'b0;
        chk("done_seen", fin, 1);
        chk("n_keys", n_got, exp_q.size());
        chk("n_key_en", n_en, 32);
        if (exp_cyc > 0) chk("done_lat", cyc, exp_cyc);
    endtask

    // ROUNDS=1 instance: exactly two keys, done 3 cycles after start with rk_ready high.
    task automatic run_b(input logic [79:0] k, input bit dv);
        int          cyc;
        int          n;
        bit          fin;
        logic [79:0] s1;
        s1 = upd(k, 1);
        @(negedge clk);
        b_key_in = dv ? s1 : k;
        b_start  = 1'b1;
        b_ready  = 1'b1;
`ifdef KEY_SCHED_INV_EN
        b_dir = dv;
`endif
        cyc = 0; n = 0; fin = 0;
        while (!fin && cyc < 20) begin
            @(negedge clk);
            b_start = 1'b0;
            cyc++;
            #1;
            if (b_done) begin
                fin = 1;
            end else if (b_valid) begin
                chk("b_key", b_rk, ((n == 1) != dv) ? s1[79:16] : k[79:16]);
                chk("b_idx", b_idx, dv ? (1 - n) : n);
                n++;
            end
        end
        chk("b_n_keys", n, 2);
        chk("b_done_lat", cyc, 3);
    endtask

    initial begin
        logic [79:0] rk_key;
        rst = 1'b1; start = 1'b1; key_in = rnd80(); rk_ready = 1'b1;
        b_start = 1'b0; b_key_in = '0; b_ready = 1'b0;
`ifdef KEY_SCHED_INV_EN
        dir = 1'b0; b_dir = 1'b0;
`endif
        // Reset with start held high: reset must win.
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_valid", rk_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_idx", rk_idx, 0);
        chk("rst_rk", rk, 0);
        chk("rst_key_en", key_en, 0);
        rst = 1'b0; start = 1'b0;

        // All-zero key, no stalls.
        fill_fwd(80'h0);
        run(80'h0, 1'b0, 0, 1'b0, 33);
        chk("zero_K1", got_q[0], 64'h0000_0000_0000_0000);
        chk("zero_K2", got_q[1], 64'hC000_0000_0000_0000);

        // All-ones key, no stalls.
        fill_fwd({80{1'b1}});
        run({80{1'b1}}, 1'b0, 0, 1'b0, 33);
        chk("ones_K1", got_q[0], 64'hFFFF_FFFF_FFFF_FFFF);
        chk("ones_K2", got_q[1], 64'h2FFF_FFFF_FFFF_FFFF);

        // Random key with random consumer stalls.
        rk_key = rnd80();
        fill_fwd(rk_key);
        run(rk_key, 1'b0, 40, 1'b0, 0);

        // start spammed while busy and alongside the final transfer, then a start right after done.
        rk_key = rnd80();
        fill_fwd(rk_key);
        run(rk_key, 1'b0, 30, 1'b1, 0);
        rk_key = rnd80();
        fill_fwd(rk_key);
        run(rk_key, 1'b0, 0, 1'b0, 33);

        // Reset in the middle of a run, together with start.
        @(negedge clk);
        key_in = rnd80(); start = 1'b1; rk_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1; start = 1'b1;
        @(negedge clk); #1;
        chk("mid_rst_valid", rk_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_idx", rk_idx, 0);
        chk("mid_rst_rk", rk, 0);
        chk("mid_rst_key_en", key_en, 0);
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        rk_key = rnd80();
        fill_fwd(rk_key);
        run(rk_key, 1'b0, 20, 1'b0, 0);

`ifdef KEY_SCHED_INV_EN
        // Inverse run from the final forward state: forward keys in reverse order.
        rk_key = rnd80();
        fill_fwd(rk_key);
        exp_q.delete();
        for (int i = 31; i >= 0; i--) exp_q.push_back({5'(i), st[i][79:16]});
        run(st[31], 1'b1, 25, 1'b0, 0);
        chk("inv_last_K1", got_q[got_q.size() - 1], rk_key[79:16]);
        run_b(rnd80(), 1'b1);
`endif
        run_b(rnd80(), 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
